// File: rtl/flog_req_arbiter.sv
// -----------------------------------------------------------------------------
// flog_req_arbiter
//
// Shares one bfloat16 log2 core between N_REQ requesters. One operand is
// accepted at a time using round-robin arbitration. It is sent to the core with
// a single-cycle start pulse. The core result is returned with the requester ID
// on a back-pressured response channel. If the core does not answer within
// TIMEOUT cycles of the start pulse, it is flushed and an error response
// carrying a quiet NaN is returned instead.
//
// Handshake rule (both channels): a transfer happens on the rising clock edge
// where valid and ready are both 1. The source holds valid and data stable
// until that edge. Dropping valid before the transfer withdraws the offer.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid_i       per-requester operand valid
//   req_ready_o       per-requester accept (one-hot or zero, only in IDLE)
//   req_data_i        packed operands, requester k at [16k+15:16k]
//   core_valid_o      one-cycle start pulse to the core
//   core_sign_o/core_exp_o/core_fract_o   operand fields to the core
//   core_flush_o      one-cycle core reset request after a watchdog expiry
//   core_done_i       core result pulse
//   core_res_i        core result, meaningful only while core_done_i=1
//   rsp_valid_o/rsp_ready_i               response handshake
//   rsp_id_o          requester that owns the response
//   rsp_data_o        log2 result (0x7FC0 on abort)
//   rsp_err_o         1 = watchdog abort
//   busy_o            an operation is in progress
// -----------------------------------------------------------------------------
module flog_req_arbiter #(
    parameter int N_REQ       = 4,
    parameter int ID_W        = 2,
    parameter int EXP_WIDTH   = 8,
    parameter int FRACT_WIDTH = 7,
    parameter int TIMEOUT     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic [N_REQ*16-1:0]    req_data_i,
    output logic                   core_valid_o,
    output logic                   core_sign_o,
    output logic [EXP_WIDTH-1:0]   core_exp_o,
    output logic [FRACT_WIDTH-1:0] core_fract_o,
    output logic                   core_flush_o,
    input  logic                   core_done_i,
    input  logic [15:0]            core_res_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [ID_W-1:0]        rsp_id_o,
    output logic [15:0]            rsp_data_o,
    output logic                   rsp_err_o,
    output logic                   busy_o
);

    localparam int                TMR_W    = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]   ID_LAST  = ID_W'(N_REQ - 1);
    localparam logic [15:0]       QNAN     = 16'h7FC0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_FLUSH = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t            state_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   rr_ptr_d;
    logic [TMR_W-1:0]  timer_q;
    logic [TMR_W-1:0]  timer_d;
    logic [15:0]       op_q;
    logic [ID_W-1:0]   id_q;
    logic [15:0]       rsp_data_q;
    logic              rsp_err_q;
    logic              rsp_valid_q;
    logic              core_valid_q;
    logic              core_flush_q;
    logic              busy_q;

    // Round-robin winner. The scan from rr_ptr upward wraps to index 0, so
    // the winner is the lowest valid index >= rr_ptr if there is one.
    // Otherwise it is the lowest valid index overall. The downward loop means
    // the last assignment seen is the lowest index.
    logic              hi_found;
    logic              lo_found;
    logic [ID_W-1:0]   hi_idx;
    logic [ID_W-1:0]   lo_idx;
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [15:0]       grant_data;

    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[k]) begin
                lo_found = 1'b1;
                lo_idx   = ID_W'(k);
                if (ID_W'(k) >= rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(k);
                end
            end
        end
        grant_found = hi_found | lo_found;
        grant_idx   = hi_found ? hi_idx : lo_idx;
    end

    assign grant_data = req_data_i[{grant_idx, 4'b0000} +: 16];
    assign rr_ptr_d   = (grant_idx == ID_LAST) ? '0 : grant_idx + ID_W'(1);
    assign timer_d    = timer_q + TMR_W'(1);

    // Accept only from IDLE. Stay silent while reset is asserted so that no
    // requester believes it was accepted on a reset edge.
    assign req_ready_o = (!rst && state_q == S_IDLE && grant_found)
                         ? (N_REQ'(1) << grant_idx) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            timer_q      <= '0;
            op_q         <= '0;
            id_q         <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            core_valid_q <= 1'b0;
            core_flush_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            core_valid_q <= 1'b0;
            core_flush_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_found) begin
                        op_q         <= grant_data;
                        id_q         <= grant_idx;
                        rr_ptr_q     <= rr_ptr_d;
                        core_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    timer_q <= timer_d;
                    // A done on the final cycle still wins over the timeout.
                    if (core_done_i) begin
                        rsp_data_q  <= core_res_i;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else if (timer_d == TMR_LAST) begin
                        core_flush_q <= 1'b1;
                        state_q      <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    rsp_data_q  <= QNAN;
                    rsp_err_q   <= 1'b1;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign core_valid_o = core_valid_q;
    assign core_flush_o = core_flush_q;
    assign core_sign_o  = op_q[15];
    assign core_exp_o   = op_q[FRACT_WIDTH +: EXP_WIDTH];
    assign core_fract_o = op_q[FRACT_WIDTH-1:0];
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = id_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_err_o    = rsp_err_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_flog_req_arbiter.sv
module tb_flog_req_arbiter;

  localparam int N  = 4;
  localparam int TO = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [N-1:0]    req_valid_i = '0;
  logic [N-1:0]    req_ready_o;
  logic [N*16-1:0] req_data_i = '0;
  logic            core_valid_o, core_sign_o, core_flush_o;
  logic [7:0]      core_exp_o;
  logic [6:0]      core_fract_o;
  logic            core_done_i = 1'b0;
  logic [15:0]     core_res_i = '0;
  logic            rsp_valid_o, rsp_err_o, busy_o;
  logic            rsp_ready_i = 1'b0;
  logic [1:0]      rsp_id_o;
  logic [15:0]     rsp_data_o;

  flog_req_arbiter #(.N_REQ(N), .ID_W(2), .EXP_WIDTH(8), .FRACT_WIDTH(7), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_data_i(req_data_i),
    .core_valid_o(core_valid_o), .core_sign_o(core_sign_o), .core_exp_o(core_exp_o),
    .core_fract_o(core_fract_o), .core_flush_o(core_flush_o),
    .core_done_i(core_done_i), .core_res_i(core_res_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o)
  );

  // ---------------- core model ----------------
  // Known log2 values for the directed cases, an arbitrary mapping otherwise.
  function automatic logic [15:0] core_fn(input logic [15:0] op);
    if (op == 16'h3F80) return 16'h0000;
    if (op == 16'h4000) return 16'h3F80;
    return op ^ 16'hA5A5;
  endfunction

  int          core_lat = 1;   // cycles from start pulse to done, 0 = never
  int          cd_cnt = 0;
  logic [15:0] cd_op = '0;
  int          spur_cyc = -1;
  int          flush_cnt = 0;

  always @(negedge clk) begin
    core_done_i = 1'b0;
    core_res_i  = 16'($urandom);
    if (cyc == spur_cyc) begin
      core_done_i = 1'b1;
      core_res_i  = 16'hDEAD;
    end else if (cd_cnt > 0) begin
      cd_cnt--;
      if (cd_cnt == 0) begin
        core_done_i = 1'b1;
        core_res_i  = core_fn(cd_op);
      end
    end
    if (core_valid_o === 1'b1) begin
      cd_cnt = core_lat;
      cd_op  = {core_sign_o, core_exp_o, core_fract_o};
    end
    if (core_flush_o === 1'b1) cd_cnt = 0;
  end

  always @(posedge clk) if (core_flush_o === 1'b1) flush_cnt <= flush_cnt + 1;

  // ---------------- requesters + reference model ----------------
  int          rem_ops[N];
  logic [15:0] rq_data[N];
  int          rsp_ready_pct = 100;
  bit          lat_rand = 1'b0;
  int          fixed_lat = 3;

  logic [18:0] exp_q[$];       // {id, data, err}
  int          grant_log[$];
  int          m_rr = 0;
  bit          m_busy = 1'b0;
  bit          m_to = 1'b0;
  int          m_accept_t = 0;
  int          m_rsp_t = 0;
  logic [15:0] m_op = '0;
  int          pend_grant = -1;
  int          tcyc = 0;

  int n_checks = 0;
  int n_fail = 0;

  function automatic int ops_left();
    int s = 0;
    for (int k = 0; k < N; k++) s += rem_ops[k];
    return s;
  endfunction

  // One clock of stimulus and checking against the model.
  task automatic tick();
    int          w;
    int          lat;
    logic [N-1:0] exp_rdy;
    logic        exp_flush;
    logic        exp_rv;
    logic [18:0] got;
    @(negedge clk);
    tcyc++;
    if (pend_grant >= 0) begin
      rem_ops[pend_grant]--;
      rq_data[pend_grant] = 16'($urandom);
    end
    for (int k = 0; k < N; k++) begin
      req_valid_i[k] = (rem_ops[k] > 0);
      req_data_i[16*k +: 16] = rq_data[k];
    end
    rsp_ready_i = ($urandom_range(99) < rsp_ready_pct);
    #1;

    n_checks++;
    if (core_valid_o !== (pend_grant >= 0)) begin
      n_fail++;
      $display("FAIL core_valid t=%0d: got %b want %b", tcyc, core_valid_o, pend_grant >= 0);
    end
    if (m_busy && tcyc > m_accept_t && tcyc < m_rsp_t - (m_to ? 1 : 0)) begin
      n_checks++;
      if ({core_sign_o, core_exp_o, core_fract_o} !== m_op) begin
        n_fail++;
        $display("FAIL core_operand t=%0d: got %h want %h", tcyc,
                 {core_sign_o, core_exp_o, core_fract_o}, m_op);
      end
    end
    pend_grant = -1;

    exp_flush = m_busy && m_to && (tcyc == m_accept_t + 1 + TO);
    n_checks++;
    if (core_flush_o !== exp_flush) begin
      n_fail++;
      $display("FAIL core_flush t=%0d: got %b want %b", tcyc, core_flush_o, exp_flush);
    end

    w = -1;
    if (!m_busy) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_rr + i) % N;
        if (w < 0 && req_valid_i[k]) w = k;
      end
    end
    exp_rdy = (w >= 0) ? N'(1 << w) : '0;
    n_checks++;
    if (req_ready_o !== exp_rdy) begin
      n_fail++;
      $display("FAIL req_ready t=%0d: got %b want %b", tcyc, req_ready_o, exp_rdy);
    end

    n_checks++;
    if (busy_o !== m_busy) begin
      n_fail++;
      $display("FAIL busy t=%0d: got %b want %b", tcyc, busy_o, m_busy);
    end

    exp_rv = m_busy && (tcyc >= m_rsp_t);
    n_checks++;
    if (rsp_valid_o !== exp_rv) begin
      n_fail++;
      $display("FAIL rsp_valid t=%0d: got %b want %b", tcyc, rsp_valid_o, exp_rv);
    end
    if (exp_rv && exp_q.size() > 0) begin
      got = {rsp_id_o, rsp_data_o, rsp_err_o};
      n_checks++;
      if (got !== exp_q[0]) begin
        n_fail++;
        $display("FAIL rsp_payload t=%0d: got id=%0d data=%h err=%b want id=%0d data=%h err=%b",
                 tcyc, got[18:17], got[16:1], got[0], exp_q[0][18:17], exp_q[0][16:1], exp_q[0][0]);
      end
      if (rsp_ready_i) begin
        void'(exp_q.pop_front());
        m_busy = 1'b0;
      end
    end

    if (w >= 0) begin
      lat = lat_rand ? (($urandom_range(9) == 0) ? 0 : int'($urandom_range(12, 1))) : fixed_lat;
      core_lat   = lat;
      m_to       = (lat == 0) || (lat >= TO);
      m_busy     = 1'b1;
      m_accept_t = tcyc;
      m_rsp_t    = tcyc + 2 + (m_to ? TO : lat);
      m_rr       = (w + 1) % N;
      m_op       = rq_data[w];
      pend_grant = w;
      grant_log.push_back(w);
      exp_q.push_back({2'(w), (m_to ? 16'h7FC0 : core_fn(rq_data[w])), m_to});
    end
  endtask

  task automatic run_until_idle(input int bound, input string name);
    int n = 0;
    while ((ops_left() > 0 || m_busy) && n < bound) begin
      tick();
      n++;
    end
    n_checks++;
    if (n >= bound || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: cycles=%0d pending=%0d want finish within %0d with 0 pending",
               name, n, exp_q.size(), bound);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid_i = '0;
    rsp_ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_busy = 1'b0;
    m_rr = 0;
    exp_q.delete();
    pend_grant = -1;
    for (int k = 0; k < N; k++) rem_ops[k] = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    req_valid_i = 4'b1111;
    req_data_i = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (req_ready_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 0000", req_ready_o);
    end
    n_checks++;
    if ({core_valid_o, core_flush_o, rsp_valid_o, busy_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000", {core_valid_o, core_flush_o, rsp_valid_o, busy_o});
    end
    n_checks++;
    if ({core_sign_o, core_exp_o, core_fract_o} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_core_op: got %h want 0000", {core_sign_o, core_exp_o, core_fract_o});
    end
    n_checks++;
    if ({rsp_id_o, rsp_data_o, rsp_err_o} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_rsp: got %h want 0", {rsp_id_o, rsp_data_o, rsp_err_o});
    end
    rst = 1'b0;
    req_valid_i = '0;
  endtask

  task automatic test_single();
    lat_rand = 1'b0;
    fixed_lat = 3;
    rsp_ready_pct = 100;
    grant_log.delete();
    rq_data[0] = 16'h3F80;
    rem_ops[0] = 1;
    run_until_idle(50, "single");
    n_checks++;
    if (grant_log.size() != 1 || grant_log[0] != 0) begin
      n_fail++;
      $display("FAIL single_grant: got %0d grants want one grant to 0", grant_log.size());
    end
  endtask

  task automatic test_fairness();
    int want[5] = '{0, 1, 2, 3, 0};
    do_reset();
    lat_rand = 1'b1;
    rsp_ready_pct = 100;
    grant_log.delete();
    for (int k = 0; k < N; k++) begin
      rem_ops[k] = 2;
      rq_data[k] = 16'h4100 + 16'(k);
    end
    run_until_idle(1500, "fairness");
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (grant_log.size() <= i || grant_log[i] != want[i]) begin
        n_fail++;
        $display("FAIL fairness_order[%0d]: got %0d want %0d", i,
                 (grant_log.size() > i) ? grant_log[i] : -1, want[i]);
      end
    end
  endtask

  task automatic test_rotation_skip();
    do_reset();
    lat_rand = 1'b0;
    fixed_lat = 2;
    rsp_ready_pct = 100;
    grant_log.delete();
    rem_ops[1] = 1;
    run_until_idle(50, "rot_setup");
    rem_ops[0] = 1;
    rem_ops[1] = 1;
    run_until_idle(80, "rot_skip");
    n_checks++;
    if (grant_log.size() != 3 || grant_log[1] != 0 || grant_log[2] != 1) begin
      n_fail++;
      $display("FAIL rotation_skip: got %0d grants want order 1,0,1", grant_log.size());
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    lat_rand = 1'b0;
    fixed_lat = 2;
    rsp_ready_pct = 0;
    rq_data[2] = 16'h4000;
    rem_ops[2] = 1;
    while (rsp_valid_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (n >= 20) begin
      n_fail++;
      $display("FAIL bp_response_seen: got none want rsp_valid within 20 cycles");
    end
    spur_cyc = cyc + 2;
    rem_ops[0] = 1;
    rq_data[0] = 16'h3C00;
    for (int i = 0; i < 10; i++) tick();
    n_checks++;
    if (rsp_valid_o !== 1'b1 || rsp_data_o !== 16'h3F80) begin
      n_fail++;
      $display("FAIL bp_hold: got valid=%b data=%h want valid=1 data=3f80", rsp_valid_o, rsp_data_o);
    end
    rsp_ready_pct = 100;
    run_until_idle(60, "backpressure");
  endtask

  task automatic test_watchdog();
    int f0;
    lat_rand = 1'b0;
    rsp_ready_pct = 100;
    f0 = flush_cnt;
    fixed_lat = 0;
    rem_ops[1] = 1;
    run_until_idle(200, "watchdog");
    n_checks++;
    if (flush_cnt - f0 != 1) begin
      n_fail++;
      $display("FAIL watchdog_flush_count: got %0d want 1", flush_cnt - f0);
    end
    fixed_lat = TO - 1;
    rem_ops[3] = 1;
    run_until_idle(200, "done_last_cycle");
    fixed_lat = TO;
    rem_ops[0] = 1;
    run_until_idle(200, "done_too_late");
    n_checks++;
    if (flush_cnt - f0 != 2) begin
      n_fail++;
      $display("FAIL late_done_flush_count: got %0d want 2", flush_cnt - f0);
    end
  endtask

  task automatic test_random();
    int total = 0;
    int g0;
    do_reset();
    lat_rand = 1'b1;
    rsp_ready_pct = 60;
    g0 = grant_log.size();
    for (int k = 0; k < N; k++) begin
      rem_ops[k] = $urandom_range(4, 1);
      rq_data[k] = 16'($urandom);
      total += rem_ops[k];
    end
    run_until_idle(5000, "random");
    n_checks++;
    if (grant_log.size() - g0 != total) begin
      n_fail++;
      $display("FAIL random_grant_count: got %0d want %0d", grant_log.size() - g0, total);
    end
  endtask

  task automatic test_reset_in_wait();
    int bad = 0;
    lat_rand = 1'b0;
    fixed_lat = 20;
    rsp_ready_pct = 100;
    rem_ops[2] = 1;
    for (int i = 0; i < 4; i++) tick();
    @(negedge clk);
    rst = 1'b1;
    req_valid_i = '0;
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({req_ready_o, core_valid_o, core_flush_o, rsp_valid_o, busy_o} !== 8'h00 ||
        {core_sign_o, core_exp_o, core_fract_o} !== 16'h0000 ||
        {rsp_id_o, rsp_data_o, rsp_err_o} !== 19'h0) begin
      n_fail++;
      $display("FAIL rst_wait_outputs: got ctrl=%b op=%h rsp=%h want all 0",
               {req_ready_o, core_valid_o, core_flush_o, rsp_valid_o, busy_o},
               {core_sign_o, core_exp_o, core_fract_o}, {rsp_id_o, rsp_data_o, rsp_err_o});
    end
    m_busy = 1'b0;
    m_rr = 0;
    exp_q.delete();
    pend_grant = -1;
    for (int k = 0; k < N; k++) rem_ops[k] = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL rst_wait_late_done: got %0d cycles with valid/busy want 0", bad);
    end
    fixed_lat = 3;
    grant_log.delete();
    rem_ops[1] = 1;
    rem_ops[3] = 1;
    run_until_idle(80, "after_reset");
    n_checks++;
    if (grant_log.size() != 2 || grant_log[0] != 1 || grant_log[1] != 3) begin
      n_fail++;
      $display("FAIL rst_wait_rr_ptr: got %0d grants want order 1,3", grant_log.size());
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int k = 0; k < N; k++) begin
      rem_ops[k] = 0;
      rq_data[k] = '0;
    end
    test_reset();
    test_single();
    test_fairness();
    test_rotation_skip();
    test_backpressure();
    test_watchdog();
    test_random();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no completion want end of sequence");
    $fatal(1, "simulation time limit");
  end

endmodule
